// File: rtl/lab_buffer_scheduler_if.sv
// Handshake between the buffer scheduler and the LAB digitizer engine.
// The scheduler drives start/abort/buffer id; the engine answers with done.
interface lab_buffer_scheduler_if;
    logic       dig_start;
    logic [1:0] dig_buf;
    logic       dig_done;
    logic       dig_abort;

    modport master (
        output dig_start,
        output dig_buf,
        input  dig_done,
        output dig_abort
    );

    modport slave (
        input  dig_start,
        input  dig_buf,
        output dig_done,
        input  dig_abort
    );
endinterface

// File: rtl/lab_buffer_scheduler.sv
// Owns the four LAB sample buffers: queues digitize requests, issues one
// digitization at a time round-robin, and frees buffers when readout completes.
module lab_buffer_scheduler #(
    parameter int NBUF           = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   clr_all_i,
    input  logic [NBUF-1:0]        digitize_i,
    input  logic [1:0]             read_buf_i,
    input  logic                   clr_evt_i,
    lab_buffer_scheduler_if.master dig,
    output logic                   lab_ready_o,
    output logic [2*NBUF-1:0]      buf_state_o,
    output logic                   busy_o,
    output logic                   overflow_o,
    output logic                   timeout_o
);
    // state   | meaning
    // S_IDLE  | nothing in flight; arbiter scans PENDING buffers from rr_q
    // S_START | one-cycle dig_start pulse for dig_buf_q
    // S_WAIT  | engine busy; waiting for dig_done or timeout

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } fsm_t;

    localparam logic [1:0]  ST_FREE  = 2'd0;
    localparam logic [1:0]  ST_PEND  = 2'd1;
    localparam logic [1:0]  ST_DIG   = 2'd2;
    localparam logic [1:0]  ST_READY = 2'd3;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    fsm_t            state_q;
    fsm_t            state_d;
    logic [1:0]      buf_st_q [NBUF];
    logic [1:0]      buf_st_d [NBUF];
    logic [1:0]      dig_buf_q;
    logic [1:0]      rr_q;
    logic [1:0]      pick_id;
    logic [1:0]      cand;
    logic            pick_valid;
    logic            tmo_hit;
    logic            ovf_hit;
    logic            abort_q;
    logic            overflow_q;
    logic            timeout_q;
    logic [15:0]     timer_q;
    logic [NBUF-1:0] released;

    // Round-robin pick: first PENDING buffer at or after rr_q, wrapping mod 4.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = rr_q;
        cand       = rr_q;
        for (int i = 0; i < NBUF; i++) begin
            cand = rr_q + 2'(i);
            if (!pick_valid && (buf_st_q[cand] == ST_PEND)) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign tmo_hit = (state_q == S_WAIT) && !dig.dig_done && (timer_q == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_all_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (pick_valid) state_d = S_START;
                S_START: state_d = S_WAIT;
                S_WAIT:  if (dig.dig_done || tmo_hit) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        dig.dig_start = (state_q == S_START);
        dig.dig_abort = abort_q | tmo_hit;
        lab_ready_o   = (buf_st_q[read_buf_i] == ST_READY);
        busy_o        = 1'b1;
        buf_state_o   = '0;
        for (int i = 0; i < NBUF; i++) begin
            buf_state_o[2*i +: 2] = buf_st_q[i];
            if (buf_st_q[i] == ST_FREE) busy_o = 1'b0;
        end
    end

    assign dig.dig_buf = dig_buf_q;
    assign overflow_o  = overflow_q;
    assign timeout_o   = timeout_q;

    // A global clear while the engine is engaged must tell it to let go,
    // unless the timeout path is already aborting in this very cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dig_buf_q <= 2'd0;
            rr_q      <= 2'd0;
            timer_q   <= 16'd0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= clr_all_i &&
                       ((state_q == S_START) || ((state_q == S_WAIT) && !tmo_hit));
            if (clr_all_i) begin
                rr_q    <= 2'd0;
                timer_q <= 16'd0;
            end else begin
                if ((state_q == S_IDLE) && pick_valid) begin
                    dig_buf_q <= pick_id;
                    rr_q      <= pick_id + 2'd1;
                end
                if (state_q == S_START) begin
                    timer_q <= 16'd0;
                end else if ((state_q == S_WAIT) && (timer_q != 16'hFFFF)) begin
                    timer_q <= timer_q + 16'd1;
                end
            end
        end
    end

    // Release is evaluated against the pre-edge state so that a request in the
    // same cycle lands on the freshly freed buffer.
    always_comb begin
        ovf_hit  = 1'b0;
        released = '0;
        for (int i = 0; i < NBUF; i++) begin
            buf_st_d[i] = buf_st_q[i];
            if (dig_buf_q == 2'(i)) begin
                if (state_q == S_START) begin
                    buf_st_d[i] = ST_DIG;
                end else if ((state_q == S_WAIT) && dig.dig_done) begin
                    buf_st_d[i] = ST_READY;
                end else if (tmo_hit) begin
                    buf_st_d[i] = ST_FREE;
                end
            end
            released[i] = clr_evt_i && (read_buf_i == 2'(i)) && (buf_st_q[i] == ST_READY);
            if (released[i]) buf_st_d[i] = ST_FREE;
            if (digitize_i[i]) begin
                if ((buf_st_q[i] == ST_FREE) || released[i]) begin
                    buf_st_d[i] = ST_PEND;
                end else begin
                    ovf_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NBUF; i++) buf_st_q[i] <= ST_FREE;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (clr_all_i) begin
            for (int i = 0; i < NBUF; i++) buf_st_q[i] <= ST_FREE;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NBUF; i++) buf_st_q[i] <= buf_st_d[i];
            if (ovf_hit) overflow_q <= 1'b1;
            if (tmo_hit) timeout_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lab_buffer_scheduler.sv
// Bench for lab_buffer_scheduler: cycle model of buffer bookkeeping checked every
// cycle, plus directed scenarios with literal expectations.
module tb_lab_buffer_scheduler;
    localparam int TMO = 16;

    logic       clk_i      = 1'b0;
    logic       rst_n_i    = 1'b0;
    logic       clr_all_i  = 1'b0;
    logic [3:0] digitize_i = 4'd0;
    logic [1:0] read_buf_i = 2'd0;
    logic       clr_evt_i  = 1'b0;
    logic       lab_ready_o;
    logic [7:0] buf_state_o;
    logic       busy_o;
    logic       overflow_o;
    logic       timeout_o;

    int n_pass  = 0;
    int n_total = 0;

    lab_buffer_scheduler_if dif ();

    lab_buffer_scheduler #(.NBUF(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clr_all_i   (clr_all_i),
        .digitize_i  (digitize_i),
        .read_buf_i  (read_buf_i),
        .clr_evt_i   (clr_evt_i),
        .dig         (dif),
        .lab_ready_o (lab_ready_o),
        .buf_state_o (buf_state_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .timeout_o   (timeout_o)
    );

    always #15 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: per-buffer states (0 free,1 pending,2 digitizing,3 ready) and the
    // engine job: whether one is assigned, whether its start pulse went out,
    // and how many WAIT cycles it has already spent.
    int ms[4]       = '{0, 0, 0, 0};
    bit m_act       = 1'b0;
    bit m_started   = 1'b0;
    int m_cur       = 0;
    int m_rr        = 0;
    int m_age       = 0;
    bit m_ovf       = 1'b0;
    bit m_to        = 1'b0;
    bit m_abort_nxt = 1'b0;

    task automatic model_reset();
        for (int b = 0; b < 4; b++) ms[b] = 0;
        m_act = 0; m_started = 0; m_cur = 0; m_rr = 0; m_age = 0;
        m_ovf = 0; m_to = 0; m_abort_nxt = 0;
    endtask

    task automatic model_step();
        int o[4];
        bit tmo_fire;
        bit freed;
        o = ms;
        tmo_fire = m_act && m_started && !dif.dig_done && (m_age == TMO - 1);
        if (clr_all_i) begin
            m_abort_nxt = m_act && !tmo_fire;
            for (int b = 0; b < 4; b++) ms[b] = 0;
            m_act = 0; m_started = 0; m_rr = 0; m_age = 0; m_ovf = 0; m_to = 0;
            return;
        end
        m_abort_nxt = 0;
        if (!m_act) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_act && o[(m_rr + k) % 4] == 1) begin
                    m_cur = (m_rr + k) % 4;
                    m_act = 1; m_started = 0;
                end
            end
            if (m_act) m_rr = (m_cur + 1) % 4;
        end else if (!m_started) begin
            ms[m_cur] = 2; m_started = 1; m_age = 0;
        end else if (dif.dig_done) begin
            ms[m_cur] = 3; m_act = 0;
        end else if (tmo_fire) begin
            ms[m_cur] = 0; m_act = 0; m_to = 1;
        end else begin
            m_age++;
        end
        for (int b = 0; b < 4; b++) begin
            freed = clr_evt_i && (int'(read_buf_i) == b) && (o[b] == 3);
            if (freed) ms[b] = 0;
            if (digitize_i[b]) begin
                if (o[b] == 0 || freed) ms[b] = 1;
                else m_ovf = 1;
            end
        end
    endtask

    task automatic model_compare();
        logic [7:0] bs;
        bit free_any;
        bs = '0;
        free_any = 0;
        for (int b = 0; b < 4; b++) begin
            bs[2*b +: 2] = 2'(ms[b]);
            if (ms[b] == 0) free_any = 1;
        end
        chk("m_buf_state", 32'(buf_state_o), 32'(bs));
        chk("m_busy",      32'(busy_o),      32'(!free_any));
        chk("m_lab_ready", 32'(lab_ready_o), 32'(ms[read_buf_i] == 3));
        chk("m_dig_start", 32'(dif.dig_start), 32'(m_act && !m_started));
        chk("m_dig_buf",   32'(dif.dig_buf),   32'(m_cur));
        chk("m_dig_abort", 32'(dif.dig_abort),
            32'(m_abort_nxt || (m_act && m_started && !dif.dig_done && m_age == TMO - 1)));
        chk("m_overflow",  32'(overflow_o), 32'(m_ovf));
        chk("m_timeout",   32'(timeout_o),  32'(m_to));
    endtask

    always @(posedge clk_i) begin
        if (!rst_n_i) model_reset();
        else model_step();
        #1;
        model_compare();
    end

    task automatic nxt();
        @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        dif.dig_done = 1'b0;
        nxt(); nxt();
        chk("rst_buf_state", 32'(buf_state_o), 32'h0);
        chk("rst_dig_start", 32'(dif.dig_start), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_flags", 32'({overflow_o, timeout_o}), 32'h0);
        rst_n_i = 1'b1;
        nxt();

        // single request, digitize, read out, release
        digitize_i = 4'b0001;
        nxt(); digitize_i = 4'd0;
        chk("t1_pending", 32'(buf_state_o), 32'h01);
        chk("t1_no_start_yet", 32'(dif.dig_start), 32'h0);
        nxt();
        chk("t1_start", 32'(dif.dig_start), 32'h1);
        chk("t1_dig_buf", 32'(dif.dig_buf), 32'h0);
        nxt();
        chk("t1_digitizing", 32'(buf_state_o), 32'h02);
        chk("t1_start_one_cycle", 32'(dif.dig_start), 32'h0);
        repeat (5) nxt();
        dif.dig_done = 1'b1;
        nxt(); dif.dig_done = 1'b0; read_buf_i = 2'd0;
        #1;
        chk("t1_ready", 32'(buf_state_o), 32'h03);
        chk("t1_lab_ready", 32'(lab_ready_o), 32'h1);
        clr_evt_i = 1'b1;
        nxt(); clr_evt_i = 1'b0;
        chk("t1_released", 32'(buf_state_o), 32'h00);
        chk("t1_lab_ready_low", 32'(lab_ready_o), 32'h0);

        // two simultaneous requests, round-robin order
        digitize_i = 4'b1010;
        nxt(); digitize_i = 4'd0;
        chk("t2_both_pending", 32'(buf_state_o), 32'h44);
        nxt();
        chk("t2_first_start", 32'(dif.dig_start), 32'h1);
        chk("t2_first_buf", 32'(dif.dig_buf), 32'h1);
        nxt();
        chk("t2_buf1_dig", 32'(buf_state_o), 32'h48);
        dif.dig_done = 1'b1;
        nxt(); dif.dig_done = 1'b0;
        chk("t2_buf1_ready", 32'(buf_state_o), 32'h4C);
        chk("t2_idle_gap", 32'(dif.dig_start), 32'h0);
        nxt();
        chk("t2_second_start", 32'(dif.dig_start), 32'h1);
        chk("t2_second_buf", 32'(dif.dig_buf), 32'h3);
        nxt();
        dif.dig_done = 1'b1;
        nxt(); dif.dig_done = 1'b0; read_buf_i = 2'd3;
        #1;
        chk("t2_both_ready", 32'(buf_state_o), 32'hCC);
        chk("t2_lab_ready_b3", 32'(lab_ready_o), 32'h1);
        read_buf_i = 2'd2;
        #1;
        chk("t2_lab_ready_b2", 32'(lab_ready_o), 32'h0);

        // fill all buffers, then overflow on a pending one
        digitize_i = 4'b0101;
        nxt(); digitize_i = 4'd0;
        chk("t3_full_state", 32'(buf_state_o), 32'hDD);
        chk("t3_busy", 32'(busy_o), 32'h1);
        nxt();
        chk("t3_rr_wrap_buf", 32'(dif.dig_buf), 32'h0);
        chk("t3_start", 32'(dif.dig_start), 32'h1);
        digitize_i = 4'b0100;
        nxt(); digitize_i = 4'd0;
        chk("t3_overflow", 32'(overflow_o), 32'h1);
        chk("t3_buf2_kept", 32'(buf_state_o), 32'hDE);

        // buf0 never completes: abort on WAIT cycle 16
        repeat (14) nxt();
        chk("t4_no_abort_early", 32'(dif.dig_abort), 32'h0);
        chk("t4_timeout_flag_low", 32'(timeout_o), 32'h0);
        nxt();
        chk("t4_abort", 32'(dif.dig_abort), 32'h1);
        nxt();
        chk("t4_abort_one_cycle", 32'(dif.dig_abort), 32'h0);
        chk("t4_buf0_freed", 32'(buf_state_o), 32'hDC);
        chk("t4_timeout", 32'(timeout_o), 32'h1);
        chk("t4_not_busy", 32'(busy_o), 32'h0);

        // global clear while digitizing buf2 with buf1/buf3 READY
        nxt();
        chk("t5_next_buf", 32'(dif.dig_buf), 32'h2);
        chk("t5_start", 32'(dif.dig_start), 32'h1);
        nxt();
        clr_all_i = 1'b1; digitize_i = 4'b0001;
        nxt(); clr_all_i = 1'b0; digitize_i = 4'd0;
        chk("t5_abort", 32'(dif.dig_abort), 32'h1);
        chk("t5_cleared", 32'(buf_state_o), 32'h0);
        chk("t5_flags", 32'({overflow_o, timeout_o}), 32'h0);
        nxt();
        chk("t5_abort_one_cycle", 32'(dif.dig_abort), 32'h0);
        chk("t5_request_discarded", 32'(buf_state_o), 32'h0);

        // async reset in the middle of WAIT
        digitize_i = 4'b0010;
        nxt(); digitize_i = 4'd0;
        nxt(); nxt();
        chk("t6_wait_state", 32'(buf_state_o), 32'h08);
        chk("t6_dig_buf", 32'(dif.dig_buf), 32'h1);
        #5 rst_n_i = 1'b0;
        #1;
        chk("t6_rst_state", 32'(buf_state_o), 32'h0);
        chk("t6_rst_dig_buf", 32'(dif.dig_buf), 32'h0);
        chk("t6_rst_outs", 32'({dif.dig_start, dif.dig_abort, lab_ready_o, busy_o,
                                overflow_o, timeout_o}), 32'h0);
        nxt(); nxt();
        rst_n_i = 1'b1;

        // release and re-request of the same buffer in one cycle
        nxt();
        digitize_i = 4'b0001;
        nxt(); digitize_i = 4'd0;
        nxt(); nxt();
        dif.dig_done = 1'b1;
        nxt(); dif.dig_done = 1'b0;
        chk("t7_ready", 32'(buf_state_o), 32'h03);
        read_buf_i = 2'd0; clr_evt_i = 1'b1; digitize_i = 4'b0001;
        nxt(); clr_evt_i = 1'b0; digitize_i = 4'd0;
        chk("t7_rerequest", 32'(buf_state_o), 32'h01);
        chk("t7_no_overflow", 32'(overflow_o), 32'h0);
        repeat (4) nxt();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
